// File: rtl/controle_nivel.sv
// Automatic tank-level controller: debounced low/high switches, fill/hold FSM
// with hysteresis, fill timeout and sensor-inconsistency fault with operator ack.
module controle_nivel #(
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       manual,
  input  logic       sensor_baixo,
  input  logic       sensor_alto,
  input  logic       reconhece,
  output logic       abre_auto,
  output logic       fecha_auto,
  output logic       erro,
  output logic [1:0] estado
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENCHENDO = 2'd1,
    CHEIO    = 2'd2,
    ERRO     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            baixo_f_q, baixo_f_d;
  logic            alto_f_q, alto_f_d;
  logic [DW-1:0]   cnt_b_q, cnt_b_d;
  logic [DW-1:0]   cnt_a_q, cnt_a_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            inc;

  // Filtered value flips only after DEBOUNCE consecutive differing samples.
  always_comb begin
    baixo_f_d = baixo_f_q;
    cnt_b_d   = '0;
    if (sensor_baixo != baixo_f_q) begin
      if (cnt_b_q == DB_LAST) baixo_f_d = sensor_baixo;
      else                    cnt_b_d   = cnt_b_q + 1'b1;
    end
    alto_f_d = alto_f_q;
    cnt_a_d  = '0;
    if (sensor_alto != alto_f_q) begin
      if (cnt_a_q == DB_LAST) alto_f_d = sensor_alto;
      else                    cnt_a_d  = cnt_a_q + 1'b1;
    end
  end

  assign inc = alto_f_q & ~baixo_f_q;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      OCIOSO: begin
        if (inc)            state_d = ERRO;
        else if (manual)    state_d = OCIOSO;
        else if (!baixo_f_q) state_d = ENCHENDO;
        else                state_d = CHEIO;
      end
      ENCHENDO: begin
        if (inc)                     state_d = ERRO;
        else if (manual)             state_d = OCIOSO;
        else if (alto_f_q)           state_d = CHEIO;
        else if (timer_q == TO_LAST) state_d = ERRO;
        else                         timer_d = timer_q + 1'b1;
      end
      CHEIO: begin
        if (inc)             state_d = ERRO;
        else if (manual)     state_d = OCIOSO;
        else if (!baixo_f_q) state_d = ENCHENDO;
      end
      ERRO: begin
        if (reconhece && !inc) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= OCIOSO;
      baixo_f_q <= 1'b0;
      alto_f_q  <= 1'b0;
      cnt_b_q   <= '0;
      cnt_a_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      baixo_f_q <= baixo_f_d;
      alto_f_q  <= alto_f_d;
      cnt_b_q   <= cnt_b_d;
      cnt_a_q   <= cnt_a_d;
      timer_q   <= timer_d;
    end
  end

  assign estado     = state_q;
  assign abre_auto  = (state_q == ENCHENDO);
  assign fecha_auto = (state_q != ENCHENDO);
  assign erro       = (state_q == ERRO);

endmodule

// File: tb/tb_controle_nivel.sv
// Bench for controle_nivel (DEBOUNCE=4, TIMEOUT=20): expected states are queued
// with the cycle they are due and compared against per-cycle output snapshots.
module tb_controle_nivel;

  logic       clock = 1'b0;
  logic       reset_n, manual, sensor_baixo, sensor_alto, reconhece;
  logic       abre_auto, fecha_auto, erro;
  logic [1:0] estado;

  controle_nivel #(.DEBOUNCE(4), .TIMEOUT(20)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .manual       (manual),
    .sensor_baixo (sensor_baixo),
    .sensor_alto  (sensor_alto),
    .reconhece    (reconhece),
    .abre_auto    (abre_auto),
    .fecha_auto   (fecha_auto),
    .erro         (erro),
    .estado       (estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned due;
    logic [1:0]  est;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests  = 0;
  int unsigned failed = 0;
  int unsigned cyc    = 0;
  int unsigned ench_t = 0;
  logic [4:0]  obs [0:1023];

  // obs[k] holds {estado,abre,fecha,erro} settled after rising edge number k.
  always @(posedge clock) begin
    #2;
    if (cyc < 1024) obs[cyc] = {estado, abre_auto, fecha_auto, erro};
    cyc = cyc + 1;
  end

  function automatic logic [4:0] exp_vec(input logic [1:0] est);
    case (est)
      2'd0:    return 5'b00_0_1_0;
      2'd1:    return 5'b01_1_0_0;
      2'd2:    return 5'b10_0_1_0;
      default: return 5'b11_0_1_1;
    endcase
  endfunction

  task automatic wait_until(input int unsigned k);
    while (cyc < k) @(negedge clock);
  endtask

  task automatic push(input string n, input int unsigned due, input logic [1:0] est);
    sb.push_back('{due: due, est: est, name: n});
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; manual = 1'b0; sensor_baixo = 1'b0; sensor_alto = 1'b0; reconhece = 1'b0;
    wait_until(2);
    push("reset_state", 1, 2'd0);
    reset_n = 1'b1;
    push("first_fill", 2, 2'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_fill();
    exp_t e;
    int unsigned b, c, d;
    b = cyc;
    sensor_baixo = 1'b1;
    wait_until(b + 1);
    sensor_alto = 1'b1;
    push("fill_before_alto", b + 4, 2'd1);
    push("fill_to_cheio", b + 5, 2'd2);
    wait_until(b + 8);
    c = cyc;
    sensor_alto = 1'b0;
    push("hyst_alto_drop", c + 4, 2'd2);
    push("hyst_hold", c + 8, 2'd2);
    wait_until(c + 9);
    d = cyc;
    sensor_baixo = 1'b0;
    push("baixo_drop_pending", d + 3, 2'd2);
    push("baixo_drop_refill", d + 4, 2'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int unsigned s, g, h;
    s = cyc;
    sensor_baixo = 1'b1; sensor_alto = 1'b1;
    push("refill_cheio", s + 4, 2'd2);
    wait_until(s + 5);
    sensor_alto = 1'b0;
    wait_until(s + 11);
    g = cyc;
    sensor_baixo = 1'b0;
    wait_until(g + 3);
    sensor_baixo = 1'b1;
    push("glitch3_a", g + 2, 2'd2);
    push("glitch3_b", g + 4, 2'd2);
    push("glitch3_c", g + 6, 2'd2);
    wait_until(g + 8);
    h = cyc;
    sensor_baixo = 1'b0;
    push("glitch4_pending", h + 3, 2'd2);
    push("glitch4_fill", h + 4, 2'd1);
    wait_until(h + 4);
    sensor_baixo = 1'b1;
    ench_t = h + 4;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int unsigned t0, r, t2;
    t0 = ench_t;
    push("timeout_last_fill", t0 + 19, 2'd1);
    push("timeout_erro", t0 + 20, 2'd3);
    wait_until(t0 + 21);
    sensor_baixo = 1'b0;
    manual = 1'b1;
    push("erro_ignores_manual", t0 + 23, 2'd3);
    wait_until(t0 + 24);
    manual = 1'b0;
    wait_until(t0 + 27);
    r = cyc;
    reconhece = 1'b1;
    push("ack_ocioso", r, 2'd0);
    push("ack_refill", r + 1, 2'd1);
    wait_until(r + 1);
    reconhece = 1'b0;
    t2 = r + 1;
    wait_until(t2 + 16);
    sensor_baixo = 1'b1; sensor_alto = 1'b1;
    push("late_alto_timer19", t2 + 19, 2'd1);
    push("alto_beats_timeout", t2 + 20, 2'd2);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_inconsistency();
    exp_t e;
    int unsigned n, m;
    n = cyc;
    sensor_baixo = 1'b0;
    push("inc_pending", n + 3, 2'd2);
    push("inc_erro", n + 4, 2'd3);
    wait_until(n + 6);
    m = cyc;
    reconhece = 1'b1;
    push("ack_while_inc", m, 2'd3);
    push("ack_while_inc_hold", m + 2, 2'd3);
    wait_until(m + 3);
    sensor_alto = 1'b0;
    push("inc_cleared_pending", m + 6, 2'd3);
    push("inc_cleared_ack", m + 7, 2'd0);
    push("ack_then_fill", m + 8, 2'd1);
    wait_until(m + 8);
    reconhece = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_manual();
    exp_t e;
    int unsigned p;
    p = cyc;
    manual = 1'b1;
    push("manual_ocioso", p, 2'd0);
    push("manual_hold", p + 3, 2'd0);
    wait_until(p + 4);
    manual = 1'b0;
    push("manual_release_fill", p + 4, 2'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  task automatic test_reset_from_erro();
    exp_t e;
    int unsigned q, s;
    q = cyc;
    sensor_alto = 1'b1;
    push("pre_reset_erro", q + 4, 2'd3);
    wait_until(q + 6);
    s = cyc;
    sensor_baixo = 1'b1;
    reset_n = 1'b0;
    push("reset_from_erro", s, 2'd0);
    wait_until(s + 1);
    reset_n = 1'b1;
    push("post_reset_filters_clear", s + 1, 2'd1);
    push("post_reset_pending", s + 4, 2'd1);
    push("post_reset_cheio", s + 5, 2'd2);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_until(e.due + 1);
      tests++;
      if (obs[e.due] !== exp_vec(e.est)) begin
        failed++;
        $display("FAIL %s: cycle %0d got {estado,abre,fecha,erro}=%b want %b", e.name, e.due, obs[e.due], exp_vec(e.est));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_glitch();
    test_timeout();
    test_inconsistency();
    test_manual();
    test_reset_from_erro();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
